// File: rtl/dec_8b10b_framer_if.sv
// Symbol-in / word-out bus of the 8b10b packet framer.
// The framer takes the master modport; the symbol source and word sink take the slave.
interface dec_8b10b_framer_if #(
    parameter int LANES = 4
);
    localparam int DATA_W = LANES * 8;

    logic              sym_valid;
    logic [DATA_W-1:0] sym_data;
    logic [LANES-1:0]  sym_is_k;
    logic [LANES-1:0]  sym_err;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eof;
    logic              out_err;
    logic              out_ready;

    modport master (
        input  sym_valid,
        input  sym_data,
        input  sym_is_k,
        input  sym_err,
        output out_valid,
        output out_data,
        output out_sof,
        output out_eof,
        output out_err,
        input  out_ready
    );

    modport slave (
        output sym_valid,
        output sym_data,
        output sym_is_k,
        output sym_err,
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_eof,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/dec_8b10b_framer.sv
// Packet framer behind an 8b10b decoder: K-code framing, header length
// decode, control-symbol extraction and an output FIFO with error reporting.
package chiplet_types_pkg;
    localparam logic [3:0] FMT_LONG_READ   = 4'h1;
    localparam logic [3:0] FMT_SHORT_READ  = 4'h2;
    localparam logic [3:0] FMT_LONG_WRITE  = 4'h3;
    localparam logic [3:0] FMT_MEM_RESP    = 4'h4;
    localparam logic [3:0] FMT_MSG         = 4'h5;
    localparam logic [3:0] FMT_SHORT_WRITE = 4'h6;
    localparam logic [3:0] FMT_SWITCH_CFG  = 4'h7;

    typedef struct packed {
        logic [3:0]  fmt;
        logic [20:0] rsvd;
        logic [6:0]  len;
    } hdr_long_t;

    typedef struct packed {
        logic [3:0]  fmt;
        logic [23:0] rsvd;
        logic [3:0]  len;
    } hdr_short_t;

    typedef union packed {
        hdr_long_t  l;
        hdr_short_t s;
    } hdr_t;
endpackage

module dec_8b10b_framer
    import chiplet_types_pkg::*;
#(
    parameter int         LANES      = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] K_START    = 8'hBC,
    parameter logic [7:0] K_END      = 8'h3C,
    parameter logic [7:0] K_ACK      = 8'h7C,
    parameter logic [7:0] K_NACK     = 8'h9C,
    parameter logic [7:0] K_RSND0    = 8'h1C,
    parameter logic [7:0] K_RSND1    = 8'h5C,
    parameter logic [7:0] K_RSND2    = 8'hDC,
    parameter logic [7:0] K_RSND3    = 8'hFC
) (
    input  logic CLK,
    input  logic nRST,
    dec_8b10b_framer_if.master bus,
    input  logic       err_clr,
    output logic       ctrl_valid,
    output logic [2:0] ctrl_sel,
    output logic       ctrl_vc,
    output logic [1:0] ctrl_id,
    output logic [4:0] ctrl_req,
    output logic       err_pulse,
    output logic [2:0] err_code,
    output logic [7:0] err_cnt,
    output logic       ovf_sticky,
    output logic       pkt_active
);
    localparam int DATA_W = LANES * 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int EW     = DATA_W + 3;
    localparam logic [AW:0] CNT_ONE  = 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, HDR, BODY, WAIT_END, DROP
    } state_t;

    state_t     state, nxt_state;
    logic [7:0] remaining, nxt_rem;

    logic [7:0] k0, lane1;
    logic       ctl, dat, bad, take;
    logic       is_start, is_end, is_ctl;
    logic [2:0] sel;

    assign k0    = bus.sym_data[7:0];
    assign lane1 = bus.sym_data[15:8];
    assign ctl   = bus.sym_valid & bus.sym_is_k[0];
    assign dat   = bus.sym_valid & ~|bus.sym_is_k;
    assign bad   = bus.sym_valid & |bus.sym_err;
    // Errored beats are ignored except in BODY, where counting carries on.
    assign take  = ~bad | (state == BODY);

    assign is_start = (k0 == K_START);
    assign is_end   = (k0 == K_END);

    always_comb begin
        sel    = 3'd0;
        is_ctl = 1'b1;
        if (k0 == K_ACK)        sel = 3'd0;
        else if (k0 == K_NACK)  sel = 3'd1;
        else if (k0 == K_RSND0) sel = 3'd2;
        else if (k0 == K_RSND1) sel = 3'd3;
        else if (k0 == K_RSND2) sel = 3'd4;
        else if (k0 == K_RSND3) sel = 3'd5;
        else                    is_ctl = 1'b0;
    end

    hdr_t              hdr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        l_long, l_short, pkt_len;

    assign hdr = bus.sym_data[31:0];

    // Low lanes go through the header view; the value is unchanged.
    always_comb begin
        wdata       = bus.sym_data;
        wdata[31:0] = hdr;
    end

    always_comb begin
        l_long  = (hdr.l.len == 7'd0) ? 8'd128 : {1'b0, hdr.l.len};
        l_short = (hdr.s.len == 4'd0) ? 8'd16 : {4'd0, hdr.s.len};
        pkt_len = 8'd0;
        unique case (hdr.l.fmt)
            FMT_LONG_READ:   pkt_len = 8'd3;
            FMT_SHORT_READ:  pkt_len = 8'd2;
            FMT_LONG_WRITE:  pkt_len = 8'd3 + l_long;
            FMT_MEM_RESP:    pkt_len = 8'd2 + l_long;
            FMT_MSG:         pkt_len = 8'd2 + l_long;
            FMT_SHORT_WRITE: pkt_len = 8'd2 + l_short;
            FMT_SWITCH_CFG:  pkt_len = 8'd1;
            default:         pkt_len = 8'd0;
        endcase
    end

    logic push, p_sof, p_eof, ctrl_hit;
    logic e_abort, e_short, e_long, e_fmt, e_kcode, e_stray;

    always_comb begin
        nxt_state = state;
        nxt_rem   = remaining;
        push      = 1'b0;
        p_sof     = 1'b0;
        p_eof     = 1'b0;
        ctrl_hit  = 1'b0;
        e_abort   = 1'b0;
        e_short   = 1'b0;
        e_long    = 1'b0;
        e_fmt     = 1'b0;
        e_kcode   = 1'b0;
        e_stray   = 1'b0;
        if (bad && state == HDR)
            nxt_state = DROP;
        if (take && ctl) begin
            if (is_ctl) begin
                ctrl_hit = 1'b1;
            end else if (is_start) begin
                e_abort   = state inside {HDR, BODY, WAIT_END};
                nxt_state = HDR;
            end else if (is_end) begin
                e_short   = state inside {HDR, BODY};
                nxt_state = IDLE;
            end else begin
                e_kcode = 1'b1;
            end
        end
        if (take && dat) begin
            unique case (state)
                IDLE: e_stray = 1'b1;
                HDR: begin
                    if (pkt_len == 8'd0) begin
                        e_fmt     = 1'b1;
                        nxt_state = DROP;
                    end else begin
                        push      = 1'b1;
                        p_sof     = 1'b1;
                        p_eof     = (pkt_len == 8'd1);
                        nxt_rem   = pkt_len - 8'd1;
                        nxt_state = p_eof ? WAIT_END : BODY;
                    end
                end
                BODY: begin
                    push    = 1'b1;
                    p_eof   = (remaining == 8'd1);
                    nxt_rem = remaining - 8'd1;
                    if (p_eof)
                        nxt_state = WAIT_END;
                end
                WAIT_END: begin
                    e_long    = 1'b1;
                    nxt_state = DROP;
                end
                default: ;
            endcase
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en, ovf;

    assign full  = (count == CNT_FULL);
    assign pop   = bus.out_valid & bus.out_ready;
    assign wr_en = push & (~full | pop);
    assign ovf   = push & full & ~pop;
    assign head  = mem[rd_ptr];

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? head[DATA_W-1:0] : '0;
    assign bus.out_sof   = bus.out_valid & head[DATA_W];
    assign bus.out_eof   = bus.out_valid & head[DATA_W+1];
    assign bus.out_err   = bus.out_valid & head[DATA_W+2];

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= {bad, p_eof, p_sof, wdata};
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    logic       err_det;
    logic [2:0] code;

    assign err_det = bad | e_abort | e_short | e_long
                   | e_fmt | e_kcode | e_stray | ovf;

    always_comb begin
        code = 3'd0;
        if (bad)          code = 3'd6;
        else if (e_abort) code = 3'd5;
        else if (e_short) code = 3'd4;
        else if (e_long)  code = 3'd3;
        else if (e_fmt)   code = 3'd2;
        else if (e_kcode) code = 3'd7;
        else if (e_stray) code = 3'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            remaining <= 8'd0;
        end else begin
            state     <= nxt_state;
            remaining <= nxt_rem;
        end
    end

    assign pkt_active = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ctrl_valid <= 1'b0;
            ctrl_sel   <= 3'd0;
            ctrl_vc    <= 1'b0;
            ctrl_id    <= 2'd0;
            ctrl_req   <= 5'd0;
            err_pulse  <= 1'b0;
            err_code   <= 3'd0;
            err_cnt    <= 8'd0;
            ovf_sticky <= 1'b0;
        end else begin
            ctrl_valid <= ctrl_hit;
            if (ctrl_hit) begin
                ctrl_sel <= sel;
                ctrl_vc  <= lane1[7];
                ctrl_id  <= lane1[6:5];
                ctrl_req <= lane1[4:0];
            end
            err_pulse <= err_det;
            err_code  <= err_det ? code : 3'd0;
            if (err_clr)
                err_cnt <= 8'd0;
            else if (err_det && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (err_clr)
                ovf_sticky <= 1'b0;
            else if (ovf)
                ovf_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dec_8b10b_framer.sv
// Directed bench for dec_8b10b_framer: framing vector table plus
// long-packet, control, overflow, symbol-error and reset sequences.
module tb_dec_8b10b_framer;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       err_clr = 1'b0;
    logic       ctrl_valid;
    logic [2:0] ctrl_sel;
    logic       ctrl_vc;
    logic [1:0] ctrl_id;
    logic [4:0] ctrl_req;
    logic       err_pulse;
    logic [2:0] err_code;
    logic [7:0] err_cnt;
    logic       ovf_sticky;
    logic       pkt_active;

    int checks = 0;
    int errors = 0;
    logic [34:0] q[$];

    dec_8b10b_framer_if #(.LANES(LANES)) bus ();

    dec_8b10b_framer #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus.master),
        .err_clr    (err_clr),
        .ctrl_valid (ctrl_valid),
        .ctrl_sel   (ctrl_sel),
        .ctrl_vc    (ctrl_vc),
        .ctrl_id    (ctrl_id),
        .ctrl_req   (ctrl_req),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_cnt    (err_cnt),
        .ovf_sticky (ovf_sticky),
        .pkt_active (pkt_active)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK)
        if (bus.out_valid && bus.out_ready)
            q.push_back({bus.out_err, bus.out_eof,
                         bus.out_sof, bus.out_data});

    typedef struct packed {
        logic        k;
        logic [31:0] d;
        logic [3:0]  e;
        logic        ep;
        logic [2:0]  ec;
        logic        act;
        logic        cv;
        logic [7:0]  cnt;
    } vec_t;

    vec_t        tv [21];
    logic [34:0] ew [5];

    task automatic chk(input string nm, input logic [34:0] act,
                       input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic k, input logic [31:0] d,
                        input logic [3:0] e);
        bus.sym_valid = 1'b1;
        bus.sym_data  = d;
        bus.sym_is_k  = k ? 4'b0001 : 4'b0000;
        bus.sym_err   = e;
        @(posedge CLK); #1;
        bus.sym_valid = 1'b0;
        bus.sym_is_k  = 4'b0000;
        bus.sym_err   = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_reset;
        nRST = 1'b0;
        idle(2);
        nRST = 1'b1;
        q.delete();
    endtask

    task automatic clr;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    initial begin
        int bad_cnt;
        bus.sym_valid = 1'b0;
        bus.sym_data  = '0;
        bus.sym_is_k  = '0;
        bus.sym_err   = '0;
        bus.out_ready = 1'b1;

        tv = '{
            '{1'b0, 32'h1111_1111, 4'h0, 1'b1, 3'd1, 1'b0, 1'b0, 8'd1},
            '{1'b1, 32'h0000_00BC, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1},
            '{1'b0, 32'h2000_0000, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1},
            '{1'b0, 32'h4444_4444, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1},
            '{1'b1, 32'h0000_003C, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd1},
            '{1'b1, 32'h0000_00BC, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1},
            '{1'b0, 32'h2000_0001, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1},
            '{1'b0, 32'h5555_5555, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1},
            '{1'b0, 32'h6666_6666, 4'h0, 1'b1, 3'd3, 1'b1, 1'b0, 8'd2},
            '{1'b1, 32'h0000_003C, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd2},
            '{1'b1, 32'h0000_00BC, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd2},
            '{1'b0, 32'hF000_0000, 4'h0, 1'b1, 3'd2, 1'b1, 1'b0, 8'd3},
            '{1'b0, 32'h7777_7777, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd3},
            '{1'b1, 32'h0000_00BC, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd3},
            '{1'b0, 32'h7000_0000, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd3},
            '{1'b1, 32'h0000_00BC, 4'h0, 1'b1, 3'd5, 1'b1, 1'b0, 8'd4},
            '{1'b1, 32'h0000_003C, 4'h0, 1'b1, 3'd4, 1'b0, 1'b0, 8'd5},
            '{1'b1, 32'h0000_00F7, 4'h0, 1'b1, 3'd7, 1'b0, 1'b0, 8'd6},
            '{1'b1, 32'h0000_007C, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 8'd6},
            '{1'b0, 32'h0000_0000, 4'h1, 1'b1, 3'd6, 1'b0, 1'b0, 8'd7},
            '{1'b1, 32'h0000_003C, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd7}
        };
        ew = '{
            {3'b001, 32'h2000_0000},
            {3'b010, 32'h4444_4444},
            {3'b001, 32'h2000_0001},
            {3'b010, 32'h5555_5555},
            {3'b011, 32'h7000_0000}
        };

        do_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_pkt_active", pkt_active, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_ctrl_valid", ctrl_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ovf", ovf_sticky, 0);

        foreach (tv[i]) begin
            beat(tv[i].k, tv[i].d, tv[i].e);
            chk($sformatf("v%0d_err_pulse", i), err_pulse, tv[i].ep);
            chk($sformatf("v%0d_err_code", i), err_code, tv[i].ec);
            chk($sformatf("v%0d_active", i), pkt_active, tv[i].act);
            chk($sformatf("v%0d_ctrl", i), ctrl_valid, tv[i].cv);
            chk($sformatf("v%0d_cnt", i), err_cnt, tv[i].cnt);
        end
        idle(3);
        chk("tbl_words", q.size(), 5);
        foreach (ew[i])
            chk($sformatf("tbl_w%0d", i), q[i], ew[i]);
        clr();
        chk("clr_cnt", err_cnt, 0);

        q.delete();
        beat(1'b1, 32'h0000_00BC, 4'h0);
        beat(1'b0, 32'h3000_0000, 4'h0);
        for (int i = 1; i <= 130; i++)
            beat(1'b0, 32'(i), 4'h0);
        chk("lw_wait_end", pkt_active, 1);
        beat(1'b1, 32'h0000_003C, 4'h0);
        idle(4);
        chk("lw_words", q.size(), 131);
        chk("lw_first", q[0], {3'b001, 32'h3000_0000});
        chk("lw_last", q[130], {3'b010, 32'd130});
        bad_cnt = 0;
        for (int i = 1; i < 130; i++)
            if (q[i] !== {3'b000, 32'(i)})
                bad_cnt++;
        chk("lw_order", bad_cnt, 0);
        chk("lw_idle", pkt_active, 0);
        chk("lw_err_cnt", err_cnt, 0);

        q.delete();
        beat(1'b1, 32'h0000_00BC, 4'h0);
        beat(1'b0, 32'h5000_0003, 4'h0);
        beat(1'b0, 32'hA1A1_A1A1, 4'h0);
        beat(1'b1, 32'h0000_A59C, 4'h0);
        chk("nack_valid", ctrl_valid, 1);
        chk("nack_sel", ctrl_sel, 1);
        chk("nack_vc", ctrl_vc, 1);
        chk("nack_id", ctrl_id, 1);
        chk("nack_req", ctrl_req, 5);
        chk("nack_active", pkt_active, 1);
        idle(1);
        chk("nack_pulse", ctrl_valid, 0);
        beat(1'b0, 32'hA2A2_A2A2, 4'h0);
        beat(1'b0, 32'hA3A3_A3A3, 4'h0);
        beat(1'b0, 32'hA4A4_A4A4, 4'h0);
        beat(1'b1, 32'h0000_003C, 4'h0);
        idle(4);
        chk("nack_words", q.size(), 5);
        chk("nack_w3", q[3], {3'b000, 32'hA3A3_A3A3});
        chk("nack_w4", q[4], {3'b010, 32'hA4A4_A4A4});
        chk("nack_err_cnt", err_cnt, 0);

        q.delete();
        bus.out_ready = 1'b0;
        beat(1'b1, 32'h0000_00BC, 4'h0);
        beat(1'b0, 32'h6000_0005, 4'h0);
        beat(1'b0, 32'hB1B1_B1B1, 4'h0);
        beat(1'b0, 32'hB2B2_B2B2, 4'h0);
        beat(1'b0, 32'hB3B3_B3B3, 4'h0);
        chk("full_no_err", err_pulse, 0);
        chk("full_valid", bus.out_valid, 1);
        beat(1'b0, 32'hB4B4_B4B4, 4'h0);
        chk("ovf_pulse", err_pulse, 1);
        chk("ovf_code", err_code, 0);
        chk("ovf_sticky", ovf_sticky, 1);
        chk("ovf_cnt", err_cnt, 1);
        bus.out_ready = 1'b1;
        idle(6);
        chk("ovf_words", q.size(), 4);
        chk("ovf_w0", q[0], {3'b001, 32'h6000_0005});
        chk("ovf_w3", q[3], {3'b000, 32'hB3B3_B3B3});

        do_reset();
        beat(1'b1, 32'h0000_00BC, 4'h0);
        beat(1'b0, 32'h1000_0000, 4'h0);
        beat(1'b0, 32'hC1C1_C1C1, 4'b0100);
        chk("serr_pulse", err_pulse, 1);
        chk("serr_code", err_code, 6);
        chk("serr_active", pkt_active, 1);
        beat(1'b1, 32'h0000_003C, 4'h0);
        chk("short_code", err_code, 4);
        chk("short_cnt", err_cnt, 2);
        chk("short_idle", pkt_active, 0);
        idle(3);
        chk("serr_words", q.size(), 2);
        chk("serr_w1", q[1], {3'b100, 32'hC1C1_C1C1});
        clr();
        chk("serr_clr", err_cnt, 0);

        q.delete();
        bus.out_ready = 1'b0;
        beat(1'b1, 32'h0000_00BC, 4'h0);
        beat(1'b0, 32'h5000_0003, 4'h0);
        beat(1'b0, 32'hD1D1_D1D1, 4'h0);
        beat(1'b0, 32'hD2D2_D2D2, 4'h0);
        chk("pre_rst_valid", bus.out_valid, 1);
        nRST = 1'b0;
        idle(1);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_active", pkt_active, 0);
        nRST = 1'b1;
        bus.out_ready = 1'b1;
        beat(1'b0, 32'hD3D3_D3D3, 4'h0);
        chk("post_rst_stray", err_code, 1);
        chk("post_rst_cnt", err_cnt, 1);
        idle(3);
        chk("post_rst_words", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_8b10b_framer.md
DEC_8B10B_FRAMER -- requirements
Module: dec_8b10b_framer

Interface
REQ-001 SHALL have parameter LANES, default 4: decoded bytes per beat; DATA_W = LANES*8; LANES >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries; power of 2, >= 2.
REQ-003 SHALL have parameters K_START=8'hBC, K_END=8'h3C, K_ACK=8'h7C, K_NACK=8'h9C, K_RSND0..3=8'h1C/5C/DC/FC: lane-0 K-code values.
REQ-004 SHALL have ports: CLK in 1, clock; nRST in 1, active-low reset, synchronous to CLK.
REQ-005 SHALL have inputs: sym_valid 1, decoded beat valid; sym_data DATA_W, lane i in bits [8i+7:8i]; sym_is_k LANES, per-lane K flag; sym_err LANES, per-lane code/disparity error; err_clr 1, clears err_cnt and ovf_sticky.
REQ-006 SHALL have outputs: out_valid 1; out_data DATA_W; out_sof 1; out_eof 1; out_err 1, word carries a code error; input out_ready 1.
REQ-007 SHALL have outputs: ctrl_valid 1, pulse; ctrl_sel 3 (0 ACK, 1 NACK, 2-5 RESEND0-3); ctrl_vc 1; ctrl_id 2; ctrl_req 5.
REQ-008 SHALL have outputs: err_pulse 1; err_code 3; err_cnt 8; ovf_sticky 1; pkt_active 1, high when FSM not IDLE.

Function
REQ-009 Control beat SHALL mean sym_valid & sym_is_k[0]; data beat SHALL mean sym_valid & ~|sym_is_k.
REQ-010 FSM states SHALL be IDLE, HDR, BODY, WAIT_END, DROP; reset to IDLE.
REQ-011 IDLE: K_START -> HDR; data beat -> err_code 1 (stray data), stay IDLE, no push.
REQ-012 HDR: data beat pushes word with out_sof=1; remaining = pkt_len-1; -> BODY if remaining>0 else WAIT_END, with out_eof=1 if pkt_len=1.
REQ-013 pkt_len SHALL be computed from header bits [31:28] using chiplet_types_pkg FMT_* codes and header-struct length fields: LONG_READ 3; SHORT_READ 2; LONG_WRITE 3+L; MEM_RESP 2+L; MSG 2+L; SHORT_WRITE 2+L; SWITCH_CFG 1; L=0 means 128 (SHORT_WRITE: 16); 8-bit unsigned count, no overflow (max 131).
REQ-014 Unknown FMT in HDR SHALL give err_code 2, no push, -> DROP.
REQ-015 BODY: each data beat pushes word, remaining decrements; word with remaining=1 SHALL carry out_eof=1; -> WAIT_END.
REQ-016 WAIT_END: K_END -> IDLE; data beat -> err_code 3 (too long), -> DROP.
REQ-017 K_END in HDR or BODY SHALL give err_code 4 (too short), -> IDLE; pushed words stay in FIFO, no eof synthesised.
REQ-018 K_START in HDR, BODY, WAIT_END SHALL give err_code 5 (abort), -> HDR.
REQ-019 DROP: discard data beats; K_END -> IDLE; K_START -> HDR.
REQ-020 Any sym_err bit on a beat SHALL give err_code 6; in HDR -> DROP, no push; in BODY word pushed with out_err=1, counting continues; other states: no state change.
REQ-021 ACK/NACK/RSND control beat SHALL pulse ctrl_valid one cycle after input, lane-1 byte decoded as {vc[7], id[6:5], req[4:0]}; SHALL be accepted in every state without changing FSM or remaining count.
REQ-022 Unrecognised lane-0 K-code SHALL give err_code 7, no state change.
REQ-023 err_pulse SHALL be one cycle, registered, one cycle after offending beat; priority of simultaneous errors: 6 > 5 > 4 > 3 > 2 > 7 > 1.
REQ-024 FIFO: push visible as out_valid the cycle after push when empty; pop on out_valid & out_ready; first-word fall-through order preserved.
REQ-025 Push when full SHALL be accepted only if same-cycle pop occurs; otherwise word dropped, ovf_sticky set, err_pulse with err_code 0.
REQ-026 err_cnt SHALL increment per err_pulse, saturate at 255; err_clr has priority over same-cycle increment.
REQ-027 Input has no backpressure; sym_valid=0 cycles SHALL not advance FSM.

Reset
REQ-028 nRST low at rising CLK SHALL set FSM IDLE, FIFO empty, all outputs 0, err_cnt 0, ovf_sticky 0.
REQ-029 Reset mid-packet SHALL discard FIFO contents and partial packet; first post-reset data beat before K_START is stray.

Verification
REQ-030 K_START, header FMT_SHORT_READ, 1 data beat, K_END -> 2 words, sof on 1st, eof on 2nd, no err_pulse.
REQ-031 K_START, FMT_LONG_WRITE L=0 -> 131 words, eof on word 131; K_END -> IDLE, err_cnt 0.
REQ-032 K_NACK with lane1=8'hA5 mid-BODY -> ctrl_valid, ctrl_sel=1, vc=1, id=1, req=5; packet completes normally.
REQ-033 out_ready=0, FIFO_DEPTH+1 words pushed -> last dropped, ovf_sticky=1, err_code 0, err_cnt=1.
REQ-034 sym_err[2] on BODY beat -> word out_err=1, err_code 6; K_END early -> err_code 4, err_cnt=2; err_clr -> 0.
REQ-035 nRST low during BODY with 3 words queued -> out_valid 0 next cycle, pkt_active 0.
